// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - launch controller cycling programs 1,2,3 per req; optional watchdog under PROG_WATCHDOG_EN
module prog_sequencer #(
    parameter int PC_W       = 10,
    parameter int PC_P1      = 0,
    parameter int PC_P2      = 256,
    parameter int PC_P3      = 512,
    parameter int WDT_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            done,
    output logic            start,
    output logic [PC_W-1:0] start_pc,
    output logic [1:0]      prog_id,
    output logic            busy,
    output logic            ack,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   req_q;
    logic   req_rise;
    logic   wdt_hit;
    logic   launching;
    logic   finishing;

    // A limit below 2 would let the watchdog fire before RUN can observe done
    if (WDT_CYCLES < 2) begin : g_wdt_cycles_too_small
        $error("WDT_CYCLES must be at least 2");
    end

    function automatic logic [PC_W-1:0] pc_sel(input logic [1:0] id);
        case (id)
            2'd1:    return PC_W'(PC_P2);
            2'd2:    return PC_W'(PC_P3);
            default: return PC_W'(PC_P1);
        endcase
    endfunction

    assign req_rise  = req & ~req_q;
    assign launching = (state_nxt == S_LAUNCH);
    assign finishing = (state == S_RUN) && (state_nxt == S_FIN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_rise) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (done || wdt_hit) state_nxt = S_FIN;
            S_FIN:    if (req_rise) state_nxt = S_LAUNCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are loaded from the next state so every port comes straight off a flop
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            req_q    <= 1'b0;
            start    <= 1'b0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            prog_id  <= 2'd0;
            start_pc <= PC_W'(PC_P1);
        end else begin
            state <= state_nxt;
            req_q <= req;
            start <= launching;
            busy  <= (state_nxt == S_LAUNCH) || (state_nxt == S_RUN);
            ack   <= (state_nxt == S_FIN);
            if (launching) begin
                start_pc <= pc_sel(prog_id);
            end
            if (finishing) begin
                prog_id <= (prog_id == 2'd2) ? 2'd0 : prog_id + 2'd1;
            end
        end
    end

`ifdef PROG_WATCHDOG_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

    logic [15:0] wdt_cnt;

    // Hit on the RUN edge that would bring the count to WDT_CYCLES
    assign wdt_hit = (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wdt_cnt     <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                wdt_cnt <= 16'd0;
            end else if (state == S_RUN) begin
                wdt_cnt <= wdt_cnt + 16'd1;
            end
            if (launching) begin
                timeout_err <= 1'b0;
            end else if (finishing) begin
                timeout_err <= ~done;
            end
        end
    end
`else
    assign wdt_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer
module tb_prog_sequencer;

    localparam int PC_W = 10;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic            req   = 1'b0;
    logic            done  = 1'b0;
    logic            start;
    logic [PC_W-1:0] start_pc;
    logic [1:0]      prog_id;
    logic            busy;
    logic            ack;
    logic            timeout_err;

    int checks      = 0;
    int failures    = 0;
    int start_count = 0;

    logic [PC_W-1:0] start_q[$];
    logic [1:0]      ack_q[$];
    logic            prev_start = 1'b0;
    logic            prev_ack   = 1'b0;

    typedef struct {
        int              delay;
        bit              stale;
        logic [PC_W-1:0] exp_pc;
        logic [1:0]      exp_pid;
    } round_t;

    round_t rounds[5];

    prog_sequencer #(
        .PC_W       (PC_W),
        .PC_P1      (0),
        .PC_P2      (256),
        .PC_P3      (512),
        .WDT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .start       (start),
        .start_pc    (start_pc),
        .prog_id     (prog_id),
        .busy        (busy),
        .ack         (ack),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (start) begin
            start_count++;
            check("start_one_cycle", 32'(prev_start), 0);
            check("start_expected", 32'(start_q.size() > 0), 1);
            if (start_q.size() > 0) check("start_pc", 32'(start_pc), 32'(start_q.pop_front()));
        end
        if (ack && !prev_ack) begin
            check("ack_expected", 32'(ack_q.size() > 0), 1);
            if (ack_q.size() > 0) check("ack_prog_id", 32'(prog_id), 32'(ack_q.pop_front()));
        end
        prev_start = start;
        prev_ack   = ack;
    end

    task automatic do_round(input round_t r);
        if (r.stale) begin
            done = 1'b1;
            ack_q.push_back(r.exp_pid);
            tick();
        end
        start_q.push_back(r.exp_pc);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("launch_start", 32'(start), 1);
        check("launch_busy", 32'(busy), 1);
        check("launch_ack", 32'(ack), 0);
        tick();
        check("run_ack", 32'(ack), 0);
        check("run_start_pc", 32'(start_pc), 32'(r.exp_pc));
        if (!r.stale) begin
            repeat (r.delay) tick();
            check("run_busy", 32'(busy), 1);
            ack_q.push_back(r.exp_pid);
            done = 1'b1;
        end
        tick();
        done = 1'b0;
        check("fin_ack", 32'(ack), 1);
        check("fin_busy", 32'(busy), 0);
        check("fin_prog_id", 32'(prog_id), 32'(r.exp_pid));
        repeat (2) tick();
        check("ack_held", 32'(ack), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        round_t r;
        int     sc;
        int     n;

        rounds[0] = '{20, 1'b0, 10'd0,   2'd1};
        rounds[1] = '{5,  1'b0, 10'd256, 2'd2};
        rounds[2] = '{1,  1'b0, 10'd512, 2'd0};
        rounds[3] = '{0,  1'b0, 10'd0,   2'd1};
        rounds[4] = '{0,  1'b1, 10'd256, 2'd2};

        reset = 1'b0;
        repeat (3) tick();
        check("rst_start", 32'(start), 0);
        check("rst_start_pc", 32'(start_pc), 0);
        check("rst_prog_id", 32'(prog_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);

        reset = 1'b1;
        done  = 1'b1;
        repeat (3) tick();
        check("idle_done_no_ack", 32'(ack), 0);
        check("idle_done_no_busy", 32'(busy), 0);
        done = 1'b0;
        tick();
        check("idle_no_ack", 32'(ack), 0);

        for (int i = 0; i < 5; i++) do_round(rounds[i]);

        // Held req level plus extra RUN-time pulses: exactly one launch
        sc = start_count;
        start_q.push_back(10'd512);
        req = 1'b1;
        repeat (50) tick();
        check("held_req_busy", 32'(busy), 1);
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        check("run_pulse_busy", 32'(busy), 1);
        ack_q.push_back(2'd0);
        done = 1'b1;
        req  = 1'b1;
        tick();
        done = 1'b0;
        check("done_wins_ack", 32'(ack), 1);
        check("done_wins_prog_id", 32'(prog_id), 0);
        tick();
        check("done_wins_no_start", 32'(start), 0);
        req = 1'b0;
        tick();
        check("held_req_one_launch", 32'(start_count - sc), 1);

        r = '{2, 1'b0, 10'd0, 2'd1};
        do_round(r);

        // Reset during RUN of program 2
        start_q.push_back(10'd256);
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (3) tick();
        check("p2_running", 32'(busy), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_ack", 32'(ack), 0);
        check("abort_prog_id", 32'(prog_id), 0);
        check("abort_start_pc", 32'(start_pc), 0);
        tick();
        check("abort_no_ack", 32'(ack), 0);
        r = '{4, 1'b0, 10'd0, 2'd1};
        do_round(r);

`ifdef PROG_WATCHDOG_EN
        start_q.push_back(10'd256);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("wdt_launch_err", 32'(timeout_err), 0);
        tick();
        ack_q.push_back(2'd2);
        n = 0;
        while (!ack && n < 300) begin
            tick();
            n++;
        end
        check("wdt_run_cycles", 32'(n), 100);
        check("wdt_timeout_err", 32'(timeout_err), 1);
        check("wdt_prog_id", 32'(prog_id), 2);
        start_q.push_back(10'd512);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("wdt_clear_on_launch", 32'(timeout_err), 0);
        tick();
        ack_q.push_back(2'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wdt_done_ack", 32'(ack), 1);
        check("wdt_done_no_err", 32'(timeout_err), 0);
`else
        n = 0;
        r = '{150, 1'b0, 10'd256, 2'd2};
        do_round(r);
        check("no_wdt_timeout_err", 32'(timeout_err), 0);
`endif

        tick();
        check("start_q_drained", 32'(start_q.size()), 0);
        check("ack_q_drained", 32'(ack_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
